// File: rtl/t_ff_monitor.sv
// Toggle monitor: synchronises a free-running toggle input, counts its transitions,
// measures the clk-cycle interval between them and flags a stall when toggling stops.
module t_ff_monitor #(
  parameter int CNT_W       = 8,
  parameter int PER_W       = 16,
  parameter int STALL_LIMIT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             t_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [PER_W-1:0] half_per,
  output logic             per_valid,
  output logic             stall,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_STALL = 2'd3;

  localparam logic [PER_W-1:0] STALL_LIM = PER_W'(STALL_LIMIT);

  logic             sync_p0;
  logic             sync_p1;
  logic             sync_p2;
  logic [1:0]       warm;
  logic             warm_done;
  logic             edge_det;
  logic [PER_W-1:0] ic;

  function automatic logic [PER_W-1:0] sat_inc(input logic [PER_W-1:0] v);
    return (&v) ? v : v + PER_W'(1);
  endfunction

  assign warm_done = warm[1];
  assign edge_det  = warm_done & (sync_p1 ^ sync_p2);
  assign stall     = (state == ST_STALL);

  // Stage p0..p2: two-flop synchroniser plus delayed copy for edge detection.
  // During warm-up the delayed copy tracks the first flop, so a high input at
  // reset release lines up with sync_p1 and produces no spurious edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      warm    <= 2'd0;
    end else begin
      sync_p0 <= t_in;
      sync_p1 <= sync_p0;
      sync_p2 <= warm_done ? sync_p1 : sync_p0;
      if (!warm_done) warm <= warm + 2'd1;
    end
  end

  // Stage p3: FSM, edge counting and interval measurement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ic         <= '0;
      toggle_cnt <= '0;
      half_per   <= '0;
      per_valid  <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= 1'b0;
      if (clear) begin
        toggle_cnt <= '0;
        half_per   <= '0;
        per_valid  <= 1'b0;
        ic         <= '0;
        state      <= enable ? ST_ARMED : ST_IDLE;
      end else if (!enable) begin
        state <= ST_IDLE;
        ic    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_ARMED;
            ic    <= '0;
          end
          ST_ARMED, ST_STALL: begin
            if (edge_det) begin
              state      <= ST_RUN;
              toggle_cnt <= toggle_cnt + CNT_W'(1);
              edge_pulse <= 1'b1;
              ic         <= PER_W'(1);
            end else begin
              ic <= sat_inc(ic);
            end
          end
          default: begin
            if (edge_det) begin
              toggle_cnt <= toggle_cnt + CNT_W'(1);
              edge_pulse <= 1'b1;
              half_per   <= ic;
              per_valid  <= 1'b1;
              ic         <= PER_W'(1);
            end else begin
              if (ic == STALL_LIM) state <= ST_STALL;
              ic <= sat_inc(ic);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t_ff_monitor.sv
// Directed bench for t_ff_monitor: table of per-cycle vectors plus hand-written
// sequences for async reset, counter wrap, interval measurement and stall recovery.
module tb_t_ff_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        t_in;
  logic        edge_pulse;
  logic [7:0]  toggle_cnt;
  logic [15:0] half_per;
  logic        per_valid;
  logic        stall;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  t_ff_monitor #(.CNT_W(8), .PER_W(16), .STALL_LIMIT(20)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .t_in(t_in),
    .edge_pulse(edge_pulse), .toggle_cnt(toggle_cnt), .half_per(half_per),
    .per_valid(per_valid), .stall(stall), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int en, clr, t;
    int ep, cnt, hp, pv, st;
  } vec_t;

  vec_t tbl[19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int ep, input int cnt, input int hp,
                       input int pv, input int st);
    vectors++;
    if (edge_pulse !== 1'(ep) || toggle_cnt !== 8'(cnt) || half_per !== 16'(hp) ||
        per_valid !== 1'(pv) || state !== 2'(st) || stall !== (st == 3)) begin
      miscompares++;
      $display("FAIL %s: got ep=%0d cnt=%0d hp=%0d pv=%0d st=%0d stall=%0d, want ep=%0d cnt=%0d hp=%0d pv=%0d st=%0d stall=%0d",
               nm, edge_pulse, toggle_cnt, half_per, per_valid, state, stall,
               ep, cnt, hp, pv, st, (st == 3));
    end
  endtask

  function automatic vec_t mk(input int en, clr, t, ep, cnt, hp, pv, st);
    vec_t v;
    v.en = en; v.clr = clr; v.t = t;
    v.ep = ep; v.cnt = cnt; v.hp = hp; v.pv = pv; v.st = st;
    return v;
  endfunction

  initial begin
    int ep_e, hp_e, st_e, cnt_e, pv_e;
    logic [7:0] run_cnt;
    bit reached;

    //            en clr t   ep cnt hp pv st
    tbl[0]  = mk(1, 0, 0,   0, 0,  0, 0, 1);
    tbl[1]  = mk(1, 0, 0,   0, 0,  0, 0, 1);
    tbl[2]  = mk(1, 0, 1,   0, 0,  0, 0, 1);
    tbl[3]  = mk(1, 0, 1,   0, 0,  0, 0, 1);
    tbl[4]  = mk(1, 0, 0,   1, 1,  0, 0, 2);
    tbl[5]  = mk(1, 0, 0,   0, 1,  0, 0, 2);
    tbl[6]  = mk(1, 0, 1,   1, 2,  2, 1, 2);
    tbl[7]  = mk(1, 0, 1,   0, 2,  2, 1, 2);
    tbl[8]  = mk(1, 1, 0,   0, 0,  0, 0, 1);
    tbl[9]  = mk(1, 0, 0,   0, 0,  0, 0, 1);
    tbl[10] = mk(1, 0, 0,   1, 1,  0, 0, 2);
    tbl[11] = mk(0, 0, 1,   0, 1,  0, 0, 0);
    tbl[12] = mk(0, 0, 1,   0, 1,  0, 0, 0);
    tbl[13] = mk(0, 0, 0,   0, 1,  0, 0, 0);
    tbl[14] = mk(1, 0, 0,   0, 1,  0, 0, 1);
    tbl[15] = mk(1, 0, 0,   1, 2,  0, 0, 2);
    tbl[16] = mk(1, 0, 1,   0, 2,  0, 0, 2);
    tbl[17] = mk(1, 0, 1,   0, 2,  0, 0, 2);
    tbl[18] = mk(1, 0, 1,   1, 3,  3, 1, 2);

    reset = 1'b0; enable = 1'b0; clear = 1'b0; t_in = 1'b0;
    repeat (3) step();
    check("reset_state", 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Table: arm, count, clear against an edge, disable while toggling, re-enable.
    for (int i = 0; i < 19; i++) begin
      enable = tbl[i].en[0];
      clear  = tbl[i].clr[0];
      t_in   = tbl[i].t[0];
      step();
      check($sformatf("tbl_%0d", i), tbl[i].ep, tbl[i].cnt, tbl[i].hp, tbl[i].pv, tbl[i].st);
    end

    // Async reset mid-cycle once toggle_cnt reaches 7.
    reached = 1'b0;
    for (int k = 0; k < 30 && !reached; k++) begin
      t_in = ~t_in;
      step();
      if (toggle_cnt == 8'd7) reached = 1'b1;
    end
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("FAIL reach_cnt7: got cnt=%0d, want 7 within 30 cycles", toggle_cnt);
    end
    #2 reset = 1'b0;
    #1 check("async_reset", 0, 0, 0, 0, 0);
    step();
    check("reset_held", 0, 0, 0, 0, 0);
    enable = 1'b1; clear = 1'b0; t_in = 1'b0;
    reset = 1'b1;

    // Toggle every clk after warm-up: half_per=1, counter wraps on 256th edge.
    for (int c = 1; c <= 263; c++) begin
      if (c >= 4) t_in = ~t_in;
      step();
      cnt_e = (c >= 6) ? ((c - 5) % 256) : 0;
      ep_e  = (c >= 6) ? 1 : 0;
      hp_e  = (c >= 7) ? 1 : 0;
      pv_e  = (c >= 7) ? 1 : 0;
      st_e  = (c >= 6) ? 2 : 1;
      check(c == 261 ? "wrap_256th" : $sformatf("fast_%0d", c), ep_e, cnt_e, hp_e, pv_e, st_e);
    end

    // Toggle every 5 clks, then hold until stall, then a single recovering toggle.
    run_cnt = 8'd2;
    for (int i = 0; i <= 48; i++) begin
      if (i == 4 || i == 9 || i == 14 || i == 19 || i == 44) t_in = ~t_in;
      step();
      ep_e = (i == 0 || i == 1 || i == 46 || (i >= 6 && i <= 21 && (i - 6) % 5 == 0)) ? 1 : 0;
      if (ep_e == 1) run_cnt = run_cnt + 8'd1;
      hp_e = (i >= 6) ? 5 : 1;
      st_e = (i >= 41 && i <= 45) ? 3 : 2;
      check($sformatf("slow_%0d", i), ep_e, int'(run_cnt), hp_e, 1, st_e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
